// File: rtl/muldiv_unit_pkg.sv
// Shared pipeline package: common word width and the ALU / MDU operation
// encodings used across the execution pipes.
package muldiv_unit_pkg;

  // Machine word width shared by the execution units.
  localparam int WORD_WIDTH = 64;

  // ALU operation encodings used by the integer pipe.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  // Multiply/divide encodings; bit 2 marks a divide-class operation and,
  // within that class, bit 1 selects the remainder.
  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring
// shift-subtract divide on operand magnitudes, sharing one shift register
// pair (hi_r:lo_r) and one iteration counter. Divide-by-zero and signed
// overflow finish immediately.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = WORD_WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  mdu_op_t         op,
  input  logic            word,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  mdu_op_t         op_r;
  logic            word_r;
  logic            neg_r;
  logic [XLEN-1:0] hi_r;
  logic [XLEN-1:0] lo_r;
  logic [XLEN-1:0] dsr_r;
  logic [XLEN-1:0] result_r;

  logic            word_eff_s, a_sgn_s, b_sgn_s, a_neg_s, b_neg_s;
  logic            div0_s, ovf_s, neg_s;
  logic [XLEN-1:0] a_ext_s, b_ext_s, a_sx_s, min_s;
  logic [XLEN-1:0] mag_a_s, mag_b_s, dvd_s, spec_res_s;
  logic [CW-1:0]   cnt_init_s;

  logic [XLEN:0]     sum_s, sh_s, diff_s;
  logic [XLEN-1:0]   nhi_s, nlo_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   mul_res_s, q_s, div_res_s, fin_s;

  assign in_ready  = (state_r == IDLE);
  // A flush in the DONE cycle cancels the pulse, so out_valid must see flush.
  assign out_valid = (state_r == DONE) && !flush;
  assign result    = result_r;

  // Decode an incoming request: operand extension, magnitudes, special cases.
  always_comb begin
    word_eff_s = word && ((op == MDU_MUL) || op[2]);
    a_sgn_s    = (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
    b_sgn_s    = (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    if (word_eff_s) begin
      a_sx_s     = XLEN'($signed(srca[31:0]));
      min_s      = XLEN'($signed(32'h8000_0000));
      cnt_init_s = CW'(32);
      if (a_sgn_s) a_ext_s = XLEN'($signed(srca[31:0]));
      else         a_ext_s = XLEN'(srca[31:0]);
      if (b_sgn_s) b_ext_s = XLEN'($signed(srcb[31:0]));
      else         b_ext_s = XLEN'(srcb[31:0]);
    end else begin
      a_sx_s     = srca;
      min_s      = {1'b1, {(XLEN-1){1'b0}}};
      cnt_init_s = CW'(XLEN);
      a_ext_s    = srca;
      b_ext_s    = srcb;
    end
    a_neg_s = a_sgn_s && a_ext_s[XLEN-1];
    b_neg_s = b_sgn_s && b_ext_s[XLEN-1];
    mag_a_s = a_neg_s ? ({XLEN{1'b0}} - a_ext_s) : a_ext_s;
    mag_b_s = b_neg_s ? ({XLEN{1'b0}} - b_ext_s) : b_ext_s;
    div0_s  = op[2] && (b_ext_s == {XLEN{1'b0}});
    ovf_s   = op[2] && a_sgn_s && (a_ext_s == min_s) && (b_ext_s == {XLEN{1'b1}});
    // Remainder follows the dividend's sign; quotient and product the XOR.
    neg_s   = (op == MDU_REM) ? a_neg_s : (a_neg_s ^ b_neg_s);
    // Word divides start with the dividend in the top half so 32 steps suffice.
    if (op[2] && word_eff_s) dvd_s = mag_a_s << (XLEN - 32);
    else                     dvd_s = mag_a_s;
    if (!op[1]) spec_res_s = div0_s ? {XLEN{1'b1}} : a_ext_s;
    else        spec_res_s = div0_s ? a_sx_s : {XLEN{1'b0}};
  end

  // One iteration step plus final sign fix-up computed from the stepped values.
  always_comb begin
    sum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, dsr_r} : {(XLEN+1){1'b0}});
    sh_s   = {hi_r, lo_r[XLEN-1]};
    diff_s = sh_s - {1'b0, dsr_r};
    if (op_r[2]) begin
      nhi_s = diff_s[XLEN] ? sh_s[XLEN-1:0] : diff_s[XLEN-1:0];
      nlo_s = {lo_r[XLEN-2:0], ~diff_s[XLEN]};
    end else begin
      nhi_s = sum_s[XLEN:1];
      nlo_s = {sum_s[0], lo_r[XLEN-1:1]};
    end
    if (neg_r) prod_s = {(2*XLEN){1'b0}} - {nhi_s, nlo_s};
    else       prod_s = {nhi_s, nlo_s};
    if (op_r == MDU_MUL) begin
      // After 32 steps the low product word sits just below the hi/lo seam.
      if (word_r) mul_res_s = XLEN'($signed(prod_s[XLEN-1 -: 32]));
      else        mul_res_s = prod_s[XLEN-1:0];
    end else begin
      mul_res_s = prod_s[2*XLEN-1:XLEN];
    end
    if (word_r) q_s = XLEN'(nlo_s[31:0]);
    else        q_s = nlo_s;
    div_res_s = op_r[1] ? nhi_s : q_s;
    if (neg_r) div_res_s = {XLEN{1'b0}} - div_res_s;
    else       div_res_s = div_res_s;
    if (word_r) div_res_s = XLEN'($signed(div_res_s[31:0]));
    else        div_res_s = div_res_s;
    fin_s = op_r[2] ? div_res_s : mul_res_s;
  end

  // Control FSM and datapath registers; flush overrides every transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= {CW{1'b0}};
      op_r     <= MDU_MUL;
      word_r   <= 1'b0;
      neg_r    <= 1'b0;
      hi_r     <= {XLEN{1'b0}};
      lo_r     <= {XLEN{1'b0}};
      dsr_r    <= {XLEN{1'b0}};
      result_r <= {XLEN{1'b0}};
    end else if (flush) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            op_r   <= op;
            word_r <= word_eff_s;
            neg_r  <= neg_s;
            hi_r   <= {XLEN{1'b0}};
            lo_r   <= dvd_s;
            dsr_r  <= mag_b_s;
            cnt_r  <= cnt_init_s;
            if (div0_s || ovf_s) begin
              result_r <= spec_res_s;
              state_r  <= DONE;
            end else begin
              state_r <= BUSY;
            end
          end
        end
        BUSY: begin
          hi_r  <= nhi_s;
          lo_r  <= nlo_s;
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            result_r <= fin_s;
            state_r  <= DONE;
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN = 64).
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  mdu_op_t         op;
  logic            word;
  logic [XLEN-1:0] srca;
  logic [XLEN-1:0] srcb;
  logic            flush;
  logic            out_valid;
  logic [XLEN-1:0] result;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .word      (word),
    .srca      (srca),
    .srcb      (srcb),
    .flush     (flush),
    .out_valid (out_valid),
    .result    (result)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request and check latency, result, single-cycle pulse, hold.
  task automatic run_op(input string tag, input mdu_op_t o, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, ".ready"}, 64'(in_ready), 64'd1);
    op = o; word = w; srca = a; srcb = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      if (i == 1 && exp_lat > 1) check({tag, ".busy"}, 64'(in_ready), 64'd0);
      if (out_valid) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    check({tag, ".res"}, result, exp_res);
    @(negedge clk);
    check({tag, ".pulse"}, 64'(out_valid), 64'd0);
    check({tag, ".hold"}, result, exp_res);
  endtask

  initial begin
    int pulses;
    reset = 1'b1; in_valid = 1'b0; op = MDU_MUL; word = 1'b0;
    srca = 64'd0; srcb = 64'd0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.ready", 64'(in_ready), 64'd1);
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.result", result, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst.ready", 64'(in_ready), 64'd1);

    run_op("mul",    MDU_MUL,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    run_op("mulhu",  MDU_MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op("mulh",   MDU_MULH,   1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("mulhsu", MDU_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op("div",    MDU_DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("rem",    MDU_REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("divu0",  MDU_DIVU,   1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remu0",  MDU_REMU,   1'b0, 64'd5, 64'd0, 64'd5, 1);
    run_op("rem0",   MDU_REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1);
    run_op("divw_ovf", MDU_DIV,  1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    run_op("remw_ovf", MDU_REM,  1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    run_op("mulw",   MDU_MUL,    1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    run_op("remw",   MDU_REM,    1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    run_op("divuw",  MDU_DIVU,   1'b1, 64'h1234_5678_8000_0000, 64'd2, 64'h0000_0000_4000_0000, 33);

    // Flush a DIV in cycle 10.
    @(negedge clk);
    op = MDU_DIV; word = 1'b0; srca = 64'd100; srcb = 64'd7; in_valid = 1'b1;
    @(posedge clk);
    pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) pulses++;
      if (i == 10) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    check("flush.ready11", 64'(in_ready), 64'd1);
    for (int i = 0; i < 80; i++) begin
      if (out_valid) pulses++;
      @(negedge clk);
    end
    check("flush.no_valid", 64'(pulses), 64'd0);
    run_op("div_after_flush", MDU_DIV, 1'b0, 64'd100, 64'd7, 64'd14, 65);

    // Flush in IDLE blocks acceptance of a request that would finish at once.
    @(negedge clk);
    op = MDU_DIVU; word = 1'b0; srca = 64'd9; srcb = 64'd0; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle.valid", 64'(out_valid), 64'd0);
    check("flush_idle.ready", 64'(in_ready), 64'd1);

    // Flush in DONE suppresses the pulse.
    @(negedge clk);
    op = MDU_DIVU; srca = 64'd9; srcb = 64'd0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1;
    #1;
    check("flush_done.valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    check("flush_done.ready", 64'(in_ready), 64'd1);
    check("flush_done.valid2", 64'(out_valid), 64'd0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    op = MDU_MUL; word = 1'b0; srca = 64'd3; srcb = 64'd5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst.ready", 64'(in_ready), 64'd1);
    check("midrst.valid", 64'(out_valid), 64'd0);
    check("midrst.result", result, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("midrst.no_valid", 64'(pulses), 64'd0);
    run_op("mul_after_rst", MDU_MUL, 1'b0, 64'd3, 64'd5, 64'd15, 65);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
